// File: rtl/sram_controller_pkg.sv
// Shared constants, state encoding and helpers for the SRAM data-memory controller.
package sram_controller_pkg;

  localparam int SRAM_DATA_LEN    = 16;
  localparam int SRAM_ADDR_LEN    = 18;
  localparam int SRAM_WAIT_CYCLES = 2;
  localparam int DATA_MEM_BASE    = 1024;

  // One word access walks IDLE -> LO half-word -> HI half-word -> DONE -> IDLE.
  typedef enum logic [1:0] {
    SRAM_IDLE = 2'd0,
    SRAM_LO   = 2'd1,
    SRAM_HI   = 2'd2,
    SRAM_DONE = 2'd3
  } sram_state_e;

  // Width of a down-counter that must hold the value cycles-1 (at least one bit).
  function automatic int cnt_width(input int cycles);
    return (cycles > 2) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/sram_controller_wait_counter.sv
// Loadable down-counter that stalls at zero; tc flags the last cycle of a hold.
module wait_counter #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             en,
  input  logic [WIDTH-1:0] value,
  output logic             tc
);

  logic [WIDTH-1:0] count;

  // Load has priority; otherwise count down while enabled and not yet at zero.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (load) begin
      count <= value;
    end else if (en && (count != '0)) begin
      count <= count - WIDTH'(1);
    end
  end

  assign tc = (count == '0);

endmodule

// File: rtl/sram_controller.sv
// Splits each 32-bit MEM-stage access into two half-word cycles on a 16-bit async SRAM.
module sram_controller
  import sram_controller_pkg::*;
#(
  parameter int SRAM_ADDR_W = SRAM_ADDR_LEN,
  parameter int WAIT_CYCLES = SRAM_WAIT_CYCLES,
  parameter int BASE_ADDR   = DATA_MEM_BASE
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic                     rd_en,
  input  logic [31:0]              address,
  input  logic [31:0]              write_data,
  output logic [31:0]              read_data,
  output logic                     ready,
  output logic [SRAM_ADDR_W-1:0]   sram_addr,
  input  logic [SRAM_DATA_LEN-1:0] sram_dq_in,
  output logic [SRAM_DATA_LEN-1:0] sram_dq_out,
  output logic                     sram_dq_oe,
  output logic                     sram_ce_n,
  output logic                     sram_oe_n,
  output logic                     sram_we_n,
  output logic                     sram_ub_n,
  output logic                     sram_lb_n
);

  localparam int               CNT_W    = cnt_width(WAIT_CYCLES);
  localparam logic [CNT_W-1:0] HOLD_VAL = CNT_W'(WAIT_CYCLES - 1);

  sram_state_e            state, next_state;
  logic                   request, accept, tc, cnt_load, cnt_en, half;
  logic                   op_write;
  logic [SRAM_ADDR_W-2:0] word_q;
  logic [31:0]            wdata_q;
  logic [31:0]            offset;
  logic                   unused_offset_bits;

  assign request  = rd_en | wr_en;
  assign accept   = (state == SRAM_IDLE) && request;
  assign offset   = address - 32'(BASE_ADDR);
  // Byte-lane bits and bits above the SRAM range are intentionally dropped.
  assign unused_offset_bits = ^{offset[31:SRAM_ADDR_W+1], offset[1:0]};

  // Reload the hold counter at the start of each half-word phase.
  assign cnt_load = accept || ((state == SRAM_LO) && tc);
  assign cnt_en   = (state == SRAM_LO) || (state == SRAM_HI);

  wait_counter #(.WIDTH(CNT_W)) u_wait (
    .clk   (clk),
    .rst   (rst),
    .load  (cnt_load),
    .en    (cnt_en),
    .value (HOLD_VAL),
    .tc    (tc)
  );

  // State register; reset lands in IDLE so the strobes drop out asynchronously.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= SRAM_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and strobe decode from the registered state.
  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    next_state  = state;
    ready       = 1'b1;
    half        = 1'b0;
    sram_ce_n   = 1'b1;
    sram_oe_n   = 1'b1;
    sram_we_n   = 1'b1;
    sram_ub_n   = 1'b1;
    sram_lb_n   = 1'b1;
    sram_dq_oe  = 1'b0;
    sram_dq_out = '0;

    unique case (state)
      SRAM_IDLE: begin
        ready = ~request;
        if (request) next_state = SRAM_LO;
      end
      SRAM_LO: begin
        ready = 1'b0;
        if (tc) next_state = SRAM_HI;
      end
      SRAM_HI: begin
        ready = 1'b0;
        half  = 1'b1;
        if (tc) next_state = SRAM_DONE;
      end
      SRAM_DONE: begin
        next_state = SRAM_IDLE;
      end
      default: next_state = SRAM_IDLE;
    endcase

    if ((state == SRAM_LO) || (state == SRAM_HI)) begin
      sram_ce_n   = 1'b0;
      sram_ub_n   = 1'b0;
      sram_lb_n   = 1'b0;
      sram_oe_n   = op_write;
      sram_we_n   = ~op_write;
      sram_dq_oe  = op_write;
      if (op_write) sram_dq_out = half ? wdata_q[31:16] : wdata_q[15:0];
    end

    sram_addr = {word_q, half};
  end

  // Latch the request at acceptance and capture read half-words on the last hold cycle.
  // NOTE: these data registers are reset because sram_addr and read_data must be 0 out of reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_write  <= 1'b0;
      word_q    <= '0;
      wdata_q   <= '0;
      read_data <= '0;
    end else begin
      if (accept) begin
        op_write <= wr_en;
        word_q   <= offset[SRAM_ADDR_W:2];
        wdata_q  <= write_data;
      end
      if ((state == SRAM_LO) && tc && !op_write) read_data[15:0]  <= sram_dq_in;
      if ((state == SRAM_HI) && tc && !op_write) read_data[31:16] <= sram_dq_in;
    end
  end

endmodule

// File: doc/sram_controller.md
# sram_controller

Multi-cycle controller that sequences the MEM stage's data-memory accesses onto an external 16-bit asynchronous SRAM. Each 32-bit word access from the MEM stage is split into two half-word SRAM cycles with programmable wait states. The block drives `ready` low for the whole access; the pipeline derives `freeze = ~ready` for every stage register, including the MEM/WB register.

## Interface
Parameters:
- `SRAM_ADDR_W`, 18, SRAM half-word address width.
- `WAIT_CYCLES`, 2, clock cycles held per half-word access (≥1).
- `BASE_ADDR`, 1024, CPU byte address mapped to SRAM word 0.

Ports:
- `clk`  in  1  pipeline clock; all state changes on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `wr_en`  in  1  MEM-stage store request (level).
- `rd_en`  in  1  MEM-stage load request (level).
- `address`  in  32  CPU byte address (word-aligned).
- `write_data`  in  32  store data.
- `read_data`  out  32  load result.
- `ready`  out  1  access complete / no access pending.
- `sram_addr`  out  SRAM_ADDR_W  half-word address.
- `sram_dq_in`  in  16  SRAM read data.
- `sram_dq_out`  out  16  SRAM write data.
- `sram_dq_oe`  out  1  drive enable for top-level tristate.
- `sram_ce_n`, `sram_oe_n`, `sram_we_n`, `sram_ub_n`, `sram_lb_n`  out  1 each  active-low SRAM strobes.

## Operation
- Address map: `word = (address - BASE_ADDR) >> 2`; `sram_addr = {word[SRAM_ADDR_W-2:0], half}`, where half=0 selects the low 16 bits and half=1 the high 16 bits. Address bits above the SRAM range are ignored. No bounds check.
- States: IDLE, LO, HI, DONE.
  - IDLE:
    - If `rd_en | wr_en`, latch the operation, address and `write_data`, then go to LO.
    - If both are asserted, perform a write.
  - LO: hold for WAIT_CYCLES cycles (down-counter), then go to HI.
  - HI: hold for WAIT_CYCLES cycles, then go to DONE.
  - DONE: one cycle, then IDLE unconditionally. A request present in DONE is not accepted there. It is sampled in the following IDLE cycle.
- `ready`:
  - Combinational.
  - In IDLE: `ready = ~(rd_en | wr_en)`.
  - In LO and HI: 0.
  - In DONE: 1.
- Strobes in LO/HI:
  - `sram_ce_n` = 0; `sram_ub_n` = `sram_lb_n` = 0.
  - Read: `sram_oe_n` = 0, `sram_we_n` = 1, `sram_dq_oe` = 0.
  - Write: `sram_we_n` = 0, `sram_oe_n` = 1, `sram_dq_oe` = 1, `sram_dq_out` = the latched half-word.
  - In IDLE and DONE, all strobes are 1, `sram_dq_oe` = 0, and `sram_dq_out` = 0.
- Read capture: on the last cycle of LO, `sram_dq_in` is registered into `read_data[15:0]`. On the last cycle of HI, it is registered into `read_data[31:16]`.
- `read_data` holds until the next read's captures. Writes leave it unchanged.
- Reset values:
  - State IDLE; counter 0; `read_data` 0.
  - All strobes 1; `sram_dq_oe` 0; `sram_addr` 0.
  - `ready` is 1 while no request is present.
- Reset asserted mid-access aborts immediately: strobes deassert asynchronously, and the partial write is not completed.

## Timing
- Request first seen at the edge ending cycle 0 (`ready` already 0 in cycle 0).
- LO occupies cycles 1..W; HI occupies cycles W+1..2W; DONE is cycle 2W+1.
- Total `ready`-low span is 2W+1 cycles (5 for W=2). The pipeline advances at the edge ending DONE.
- `read_data` is valid from cycle 2W+1 (registered at the edge ending HI) and is stable through DONE.
- Outputs are registered from state, except `ready`, which depends combinationally on `rd_en`/`wr_en` in IDLE.
- Back-to-back accesses: the second access's LO starts no earlier than cycle 2W+3, because of the mandatory IDLE cycle after DONE.

## Structure
- Shared constants go in `Constants.v`:
  - `SRAM_DATA_LEN` (16)
  - `SRAM_ADDR_LEN` (18)
  - `SRAM_WAIT_CYCLES` (2)
  - `DATA_MEM_BASE` (1024)
  - state encodings `SRAM_IDLE`, `SRAM_LO`, `SRAM_HI`, `SRAM_DONE`
- One natural sub-module, `wait_counter`: a loadable down-counter with a terminal-count output, used for the WAIT_CYCLES hold. Everything else is in-line.
- The tristate `sram_dq` lives in the top level, not in this block.

## Test plan
- Reset with no request → `ready`=1, `read_data`=0, `sram_ce_n`/`sram_we_n`/`sram_oe_n`=1.
- Write, W=2, `address`=1024, `write_data`=0xDEADBEEF:
  - `ready` low for exactly 5 cycles.
  - `sram_addr`=0 with `sram_dq_out`=0xBEEF for 2 cycles, then `sram_addr`=1 with 0xDEAD for 2 cycles.
  - `sram_we_n`=0 throughout LO/HI.
- Read `address`=1028 with an SRAM model holding 0x1234 at half-word 2 and 0xABCD at half-word 3 → `read_data`=0xABCD1234 in the DONE cycle; `sram_oe_n`=0 and `sram_dq_oe`=0 during access.
- `rd_en` and `wr_en` both high → a write is performed (`sram_we_n`=0) and `read_data` is unchanged.
- Back-to-back load then store with requests held continuously → a single IDLE cycle between DONE and the next LO; the second access is correct.
- `rst` pulsed low during HI of a write → strobes deassert within the reset cycle; after release, the state is IDLE and `ready` follows the request inputs.
